alu_muldiv: RTL and testbench



---
 rtl/alu_pkg.sv | 50 +++++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 rtl/alu_muldiv.sv | 85 ++++++++
 tb/tb_alu_muldiv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, engine states and op-classification helpers for the
// EX-stage ALU with its iterative multiply/divide engine.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SLTU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_SUB   = 4'd6,
    OP_SLT   = 4'd7,
    OP_MULT  = 4'd8,
    OP_MULTU = 4'd9,
    OP_DIV   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_NOR   = 4'd12,
    OP_XOR   = 4'd13,
    OP_MFHI  = 4'd14,
    OP_MFLO  = 4'd15
  } alu_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_CALC = 1'b1
  } md_state_e;

  function automatic logic is_md_op(input alu_op_e op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md_op = 1'b1;
      default:                            is_md_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input alu_op_e op);
    case (op)
      OP_MULT, OP_DIV: is_signed_op = 1'b1;
      default:         is_signed_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    case (op)
      OP_DIV, OP_DIVU: is_div_op = 1'b1;
      default:         is_div_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide bit per
// cycle on operand magnitudes, with sign correction applied to the last step.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic             res_we,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e          state_r, state_nx_s;
  logic [CW-1:0]      cnt_r, cnt_nx_s;
  logic [2*WIDTH-1:0] work_r, work_nx_s, step_s, prod_s;
  logic [WIDTH-1:0]   opnd_r, opnd_nx_s, a_raw_r, a_mag_s, b_mag_s, quo_s, rem_s;
  logic [WIDTH:0]     sum_s, trial_s;
  logic               is_div_r, neg_q_r, neg_r_r, dz_r;
  logic               busy_r, done_r, divzero_r, last_s, accept_s;

  assign accept_s = (state_r == MD_IDLE) && start;

  // Operand magnitudes for signed ops
  always_comb begin
    a_mag_s = a;
    b_mag_s = b;
    if (is_signed_op(op) && a[WIDTH-1]) a_mag_s = -a;
    else                                a_mag_s = a;
    if (is_signed_op(op) && b[WIDTH-1]) b_mag_s = -b;
    else                                b_mag_s = b;
  end

  // One iteration: work holds {hi,lo} for multiply, {rem,quo} for divide
  always_comb begin
    sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]}
            + (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    trial_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]} - {1'b0, opnd_r};
    step_s  = work_r;
    if (!is_div_r)          step_s = {sum_s, work_r[WIDTH-1:1]};
    else if (!trial_s[WIDTH]) step_s = {trial_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
    else                    step_s = {work_r[2*WIDTH-2:0], 1'b0};
  end

  // Sign correction and divide-by-zero override of the final step
  always_comb begin
    prod_s = step_s;
    quo_s  = step_s[WIDTH-1:0];
    rem_s  = step_s[2*WIDTH-1:WIDTH];
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (neg_q_r) begin
      prod_s = -step_s;
      quo_s  = -step_s[WIDTH-1:0];
    end else begin
      prod_s = step_s;
      quo_s  = step_s[WIDTH-1:0];
    end
    if (neg_r_r) rem_s = -step_s[2*WIDTH-1:WIDTH];
    else         rem_s = step_s[2*WIDTH-1:WIDTH];
    if (!is_div_r) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else if (dz_r) begin
      res_hi = a_raw_r;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = rem_s;
      res_lo = quo_s;
    end
  end

  // Engine FSM next-state and datapath load/iterate
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    work_nx_s  = work_r;
    opnd_nx_s  = opnd_r;
    last_s     = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (start) begin
          state_nx_s = MD_CALC;
          cnt_nx_s   = CW'(WIDTH);
          if (is_div_op(op)) begin
            work_nx_s = {{WIDTH{1'b0}}, a_mag_s};
            opnd_nx_s = b_mag_s;
          end else begin
            work_nx_s = {{WIDTH{1'b0}}, b_mag_s};
            opnd_nx_s = a_mag_s;
          end
        end else begin
          state_nx_s = MD_IDLE;
        end
      end
      MD_CALC: begin
        work_nx_s = step_s;
        if (cnt_r == CW'(1)) begin
          last_s     = 1'b1;
          state_nx_s = MD_IDLE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      default: state_nx_s = MD_IDLE;
    endcase
  end

  // Engine state, operands and status flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= MD_IDLE;
      cnt_r     <= {CW{1'b0}};
      work_r    <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      a_raw_r   <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      dz_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      work_r    <= work_nx_s;
      opnd_r    <= opnd_nx_s;
      busy_r    <= (state_nx_s == MD_CALC);
      done_r    <= last_s;
      divzero_r <= last_s & dz_r;
      if (accept_s) begin
        a_raw_r  <= a;
        is_div_r <= is_div_op(op);
        neg_q_r  <= is_signed_op(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r_r  <= is_signed_op(op) & is_div_op(op) & a[WIDTH-1];
        dz_r     <= is_div_op(op) & (b == {WIDTH{1'b0}});
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign divzero = divzero_r;
  assign res_we  = last_s;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: combinational logic/arithmetic result mux plus architectural
// HI/LO registers written by MTHI/MTLO or by the multiply/divide engine.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_con_Start,
  input  logic [3:0]       i_con_AluCtrl,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  output logic [WIDTH-1:0] o_data_AluRes,
  output logic             o_con_Zero,
  output logic             o_con_Busy,
  output logic             o_con_Done,
  output logic             o_con_DivZero,
  output logic [WIDTH-1:0] o_data_Hi,
  output logic [WIDTH-1:0] o_data_Lo
);

  alu_op_e          op_s;
  logic             busy_s, res_we_s, md_start_s, mt_ok_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s, hi_r, lo_r, alu_res_s;

  assign op_s       = alu_op_e'(i_con_AluCtrl);
  assign md_start_s = i_con_Start & is_md_op(op_s);
  assign mt_ok_s    = i_con_Start & ~busy_s;

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (md_start_s),
    .op      (op_s),
    .a       (i_data_A),
    .b       (i_data_B),
    .busy    (busy_s),
    .done    (o_con_Done),
    .divzero (o_con_DivZero),
    .res_we  (res_we_s),
    .res_hi  (res_hi_s),
    .res_lo  (res_lo_s)
  );

  // Combinational result mux; sequential codes read as zero
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    case (op_s)
      OP_AND:  alu_res_s = i_data_A & i_data_B;
      OP_OR:   alu_res_s = i_data_A | i_data_B;
      OP_ADD:  alu_res_s = i_data_A + i_data_B;
      OP_SUB:  alu_res_s = i_data_A - i_data_B;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(i_data_A) < $signed(i_data_B))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (i_data_A < i_data_B)};
      OP_NOR:  alu_res_s = ~(i_data_A | i_data_B);
      OP_XOR:  alu_res_s = i_data_A ^ i_data_B;
      OP_MFHI: alu_res_s = hi_r;
      OP_MFLO: alu_res_s = lo_r;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // HI/LO write arbitration; engine writes only while busy, so MT* never collides
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (res_we_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if (mt_ok_s && (op_s == OP_MTHI)) begin
      hi_r <= i_data_A;
    end else if (mt_ok_s && (op_s == OP_MTLO)) begin
      lo_r <= i_data_A;
    end
  end

  assign o_data_AluRes = alu_res_s;
  assign o_con_Zero    = (alu_res_s == {WIDTH{1'b0}});
  assign o_con_Busy    = busy_s;
  assign o_data_Hi     = hi_r;
  assign o_data_Lo     = lo_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised self-checking bench for alu_muldiv against a plain-arithmetic
// reference model of the ALU and HI/LO semantics.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_con_Start = 1'b0;
  logic [3:0]   i_con_AluCtrl = 4'd0;
  logic [W-1:0] i_data_A = '0;
  logic [W-1:0] i_data_B = '0;
  logic [W-1:0] o_data_AluRes, o_data_Hi, o_data_Lo;
  logic         o_con_Zero, o_con_Busy, o_con_Done, o_con_DivZero;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  alu_muldiv #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_con_Start   (i_con_Start),
    .i_con_AluCtrl (i_con_AluCtrl),
    .i_data_A      (i_data_A),
    .i_data_B      (i_data_B),
    .o_data_AluRes (o_data_AluRes),
    .o_con_Zero    (o_con_Zero),
    .o_con_Busy    (o_con_Busy),
    .o_con_Done    (o_con_Done),
    .o_con_DivZero (o_con_DivZero),
    .o_data_Hi     (o_data_Hi),
    .o_data_Lo     (o_data_Lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      4'd13:   return a ^ b;
      4'd14:   return hi_m;
      4'd15:   return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  // returns {divzero, hi, lo}
  function automatic logic [64:0] md_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd8: begin
        p = sa * sb;
        return {1'b0, p};
      end
      4'd9: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      4'd10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic comb_check(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    exp = alu_ref(op, a, b);
    i_con_AluCtrl = op;
    i_data_A = a;
    i_data_B = b;
    #1;
    check_val($sformatf("alu_op%0d", op), o_data_AluRes, exp);
    check_val($sformatf("zero_op%0d", op), o_con_Zero, (exp == 0));
  endtask

  // Starts a mul/div at the current drive point and returns in its Done cycle.
  task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit intrude);
    logic [64:0] exp;
    int bad;
    bad = 0;
    exp = md_ref(op, a, b);
    i_con_Start = 1'b1;
    i_con_AluCtrl = op;
    i_data_A = a;
    i_data_B = b;
    #1;
    check_val("seq_res_zero", o_data_AluRes, 0);
    @(posedge i_clk); #1;
    i_con_Start = 1'b0;
    i_con_AluCtrl = 4'd14;
    for (int i = 0; i < W; i++) begin
      if (o_con_Busy !== 1'b1 || o_con_Done !== 1'b0) bad++;
      if (i == 3) begin
        #1;
        check_val("mfhi_while_busy", o_data_AluRes, hi_m);
      end
      if (intrude && i == 5) begin
        i_con_Start = 1'b1;
        i_con_AluCtrl = 4'd9;
        i_data_A = $urandom;
        i_data_B = $urandom;
      end
      if (intrude && i == 6) i_con_AluCtrl = 4'd4;
      if (intrude && i == 7) i_con_AluCtrl = 4'd5;
      if (intrude && i == 8) begin
        i_con_Start = 1'b0;
        i_con_AluCtrl = 4'd14;
      end
      @(posedge i_clk); #1;
    end
    check_val($sformatf("busy_window_op%0d", op), bad, 0);
    check_val("done_pulse", o_con_Done, 1'b1);
    check_val("busy_dropped", o_con_Busy, 1'b0);
    check_val($sformatf("divzero_op%0d", op), o_con_DivZero, exp[64]);
    check_val($sformatf("hi_op%0d", op), o_data_Hi, exp[63:32]);
    check_val($sformatf("lo_op%0d", op), o_data_Lo, exp[31:0]);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  initial begin
    int bad;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    #1 i_rst_n = 1'b0;
    #2;
    check_val("rst_busy", o_con_Busy, 1'b0);
    check_val("rst_done", o_con_Done, 1'b0);
    check_val("rst_divzero", o_con_DivZero, 1'b0);
    check_val("rst_hi", o_data_Hi, 0);
    check_val("rst_lo", o_data_Lo, 0);
    check_val("rst_alures", o_data_AluRes, 0);
    check_val("rst_zero", o_con_Zero, 1'b1);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // directed combinational boundaries
    comb_check(4'd2, 32'hFFFF_FFFF, 32'd1);
    check_val("add_wrap", o_data_AluRes, 0);
    comb_check(4'd7, 32'hFFFF_FFFF, 32'd1);
    check_val("slt_neg", o_data_AluRes, 1);
    comb_check(4'd3, 32'hFFFF_FFFF, 32'd1);
    check_val("sltu_big", o_data_AluRes, 0);
    comb_check(4'd12, 32'd0, 32'd0);
    check_val("nor_zero", o_data_AluRes, 32'hFFFF_FFFF);
    comb_check(4'd6, 32'd0, 32'd1);

    for (int k = 0; k < 24; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (k % 5 == 0) ? ra : $urandom;
      comb_check(rop, ra, rb);
    end

    // MTHI / MTLO single-cycle writes
    @(posedge i_clk); #1;
    i_con_Start = 1'b1; i_con_AluCtrl = 4'd4; i_data_A = 32'h1234;
    @(posedge i_clk); #1;
    i_con_Start = 1'b0; i_con_AluCtrl = 4'd14;
    #1;
    check_val("mthi_mfhi", o_data_AluRes, 32'h1234);
    check_val("mthi_nobusy", o_con_Busy, 1'b0);
    hi_m = 32'h1234;
    i_con_Start = 1'b1; i_con_AluCtrl = 4'd5; i_data_A = 32'hCAFE_0001;
    @(posedge i_clk); #1;
    i_con_Start = 1'b0; i_con_AluCtrl = 4'd15;
    #1;
    check_val("mtlo_mflo", o_data_AluRes, 32'hCAFE_0001);
    check_val("mtlo_hi_kept", o_data_Hi, 32'h1234);
    lo_m = 32'hCAFE_0001;
    @(posedge i_clk); #1;

    // directed mul/div, issued back-to-back
    run_md(4'd8,  32'hFFFF_FFFD, 32'd7, 1'b0);
    run_md(4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_md(4'd10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_md(4'd11, 32'd7, 32'd2, 1'b0);
    run_md(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_md(4'd11, 32'd5, 32'd0, 1'b0);
    run_md(4'd10, 32'hFFFF_FFF0, 32'd0, 1'b0);
    run_md(4'd8,  32'd3, 32'd5, 1'b1);

    for (int k = 0; k < 12; k++) begin
      rop = 4'(8 + $urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ((k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      run_md(rop, ra, rb, (k == 7));
    end
    @(posedge i_clk); #1;
    check_val("done_one_cycle", o_con_Done, 1'b0);

    // reset in the middle of a divide
    i_con_Start = 1'b1; i_con_AluCtrl = 4'd10; i_data_A = 32'd1000; i_data_B = 32'd7;
    @(posedge i_clk); #1;
    i_con_Start = 1'b0; i_con_AluCtrl = 4'd14;
    repeat (9) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    check_val("midrst_busy", o_con_Busy, 1'b0);
    check_val("midrst_done", o_con_Done, 1'b0);
    check_val("midrst_hi", o_data_Hi, 0);
    check_val("midrst_lo", o_data_Lo, 0);
    hi_m = '0;
    lo_m = '0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge i_clk); #1;
      if (o_con_Done !== 1'b0 || o_con_Busy !== 1'b0) bad++;
    end
    check_val("no_done_after_rst", bad, 0);
    comb_check(4'd14, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
